rf_wport_arbiter: RTL and testbench

Write-back port arbiter for the CPU_54 register file. It sits in front of the single GPR write port and has two requesters:
- the in-order pipeline write-back, whose destination is selected rt/rd/$31 exactly as the write-address mux does;
- completions from long-latency units (DIV/DIVU, MUL, MFC0 return path), buffered in a small in-order queue.

It stalls the pipeline only when the queue must drain. It squashes queued results that a younger pipeline write to the same register makes stale.

---
 rtl/rf_wport_arbiter.sv | 148 ++++++++++++++
 tb/tb_rf_wport_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wport_arbiter.sv
// rf_wport_arbiter
//
// Shares the single GPR write port between the in-order pipeline write-back
// and a small in-order queue of long-latency completions (DIV/MUL/MFC0).
// The pipeline normally wins. It is stalled only when the queue is full,
// and then the queue head is drained instead. A granted pipeline write
// invalidates any queued result for the same register. Those results would
// otherwise land later and overwrite the younger value.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   p_valid    pipeline write-back request
//   p_sel      destination select: 00=p_rt, 01=p_rd, 1x=LINK_REG
//   p_rt/p_rd  candidate pipeline destinations
//   p_data     pipeline write data
//   p_stall    pipeline request refused this cycle (combinational)
//   l_valid    long-latency result offered
//   l_addr     long-latency destination
//   l_data     long-latency data
//   l_ready    queue can take a result (registered state only)
//   rf_we      register-file write enable (registered)
//   rf_waddr   register-file write address (registered)
//   rf_wdata   register-file write data (registered)
//   pq_count   occupied queue slots, squashed slots included

module rf_wport_arbiter #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int LINK_REG = 31,
    parameter int PQ_DEPTH = 2,
    localparam int PW      = $clog2(PQ_DEPTH),
    localparam int CW      = $clog2(PQ_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p_valid,
    input  logic [1:0]        p_sel,
    input  logic [ADDR_W-1:0] p_rt,
    input  logic [ADDR_W-1:0] p_rd,
    input  logic [DATA_W-1:0] p_data,
    output logic              p_stall,
    input  logic              l_valid,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [DATA_W-1:0] l_data,
    output logic              l_ready,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [CW-1:0]     pq_count
);

    logic [PW-1:0]     wptr;
    logic [PW-1:0]     rptr;
    logic [CW-1:0]     count;
    logic [PQ_DEPTH-1:0] ent_valid;
    logic [ADDR_W-1:0] ent_addr [PQ_DEPTH];
    logic [DATA_W-1:0] ent_data [PQ_DEPTH];

    logic              full;
    logic              empty;
    logic [ADDR_W-1:0] p_dest;
    logic              grant;
    logic              p_write;
    logic              enq;
    logic              deq;

    always_comb begin
        full  = (count == CW'(PQ_DEPTH));
        empty = (count == '0);

        case (p_sel)
            2'b00:   p_dest = p_rt;
            2'b01:   p_dest = p_rd;
            default: p_dest = ADDR_W'(LINK_REG);
        endcase

        // Pipeline has priority unless the queue is full. In that case the
        // head drains, so the stalled request is granted on the next cycle.
        grant   = p_valid && !full;
        p_write = grant && (p_dest != '0);
        deq     = (p_valid && full) || (!p_valid && !empty);

        // Results for r0 are accepted but never stored.
        enq     = l_valid && !full && (l_addr != '0);

        l_ready  = !rst && !full;
        p_stall  = !rst && p_valid && full;
        pq_count = rst ? '0 : count;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we     <= 1'b0;
            rf_waddr  <= '0;
            rf_wdata  <= '0;
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            ent_valid <= '0;
        end else begin
            rf_we <= 1'b0;
            if (p_write) begin
                rf_we    <= 1'b1;
                rf_waddr <= p_dest;
                rf_wdata <= p_data;
            end else if (deq && ent_valid[rptr]) begin
                rf_we    <= 1'b1;
                rf_waddr <= ent_addr[rptr];
                rf_wdata <= ent_data[rptr];
            end

            if (deq) begin
                ent_valid[rptr] <= 1'b0;
                rptr            <= rptr + PW'(1);
            end

            // WAW squash of older queued results. The enqueue below comes
            // later in the block, so a same-cycle arrival keeps valid=1.
            for (int i = 0; i < PQ_DEPTH; i++) begin
                if (p_write && (ent_addr[i] == p_dest)) begin
                    ent_valid[i] <= 1'b0;
                end
            end

            if (enq) begin
                ent_valid[wptr] <= 1'b1;
                wptr            <= wptr + PW'(1);
            end

            case ({enq, deq})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload storage needs no reset; a slot is only read while its valid
    // bit is set, and that bit is reset above.
    always_ff @(posedge clk) begin
        if (!rst && enq) begin
            ent_addr[wptr] <= l_addr;
            ent_data[wptr] <= l_data;
        end
    end

endmodule

// File: tb/tb_rf_wport_arbiter.sv
module tb_rf_wport_arbiter;

    localparam int D = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        p_valid = 1'b0;
    logic [1:0]  p_sel = 2'b00;
    logic [4:0]  p_rt = '0;
    logic [4:0]  p_rd = '0;
    logic [31:0] p_data = '0;
    logic        p_stall;
    logic        l_valid = 1'b0;
    logic [4:0]  l_addr = '0;
    logic [31:0] l_data = '0;
    logic        l_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [1:0]  pq_count;

    int checks = 0;
    int passes = 0;

    rf_wport_arbiter #(
        .ADDR_W(5), .DATA_W(32), .LINK_REG(31), .PQ_DEPTH(D)
    ) dut (
        .clk(clk), .rst(rst),
        .p_valid(p_valid), .p_sel(p_sel), .p_rt(p_rt), .p_rd(p_rd),
        .p_data(p_data), .p_stall(p_stall),
        .l_valid(l_valid), .l_addr(l_addr), .l_data(l_data), .l_ready(l_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .pq_count(pq_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    endtask

    // Behavioural model: queue of pending results plus expected write port.
    typedef struct {
        bit          v;
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t        mq[$];
    logic        m_we = 1'b0;
    logic [4:0]  m_waddr = '0;
    logic [31:0] m_wdata = '0;

    initial begin
        forever begin
            int         sz;
            logic [4:0] dest;
            ent_t       e;
            bit         e_stall;
            bit         e_ready;
            @(negedge clk);
            sz      = mq.size();
            e_stall = !rst && p_valid && (sz == D);
            e_ready = !rst && (sz < D);
            check("model_p_stall", 32'(p_stall), 32'(e_stall));
            check("model_l_ready", 32'(l_ready), 32'(e_ready));
            check("model_pq_count", 32'(pq_count), rst ? 32'd0 : 32'(sz));
            check("model_rf_we", 32'(rf_we), 32'(m_we));
            if (m_we) begin
                check("model_rf_waddr", 32'(rf_waddr), 32'(m_waddr));
                check("model_rf_wdata", rf_wdata, m_wdata);
            end

            if (rst) begin
                mq.delete();
                m_we    = 1'b0;
                m_waddr = '0;
                m_wdata = '0;
            end else begin
                dest = (p_sel == 2'b00) ? p_rt : (p_sel == 2'b01) ? p_rd : 5'd31;
                m_we = 1'b0;
                if (p_valid && sz < D) begin
                    if (dest != 0) begin
                        m_we    = 1'b1;
                        m_waddr = dest;
                        m_wdata = p_data;
                        foreach (mq[i]) if (mq[i].a == dest) mq[i].v = 1'b0;
                    end
                end else if (sz > 0) begin
                    e = mq.pop_front();
                    if (e.v) begin
                        m_we    = 1'b1;
                        m_waddr = e.a;
                        m_wdata = e.d;
                    end
                end
                if (l_valid && sz < D && l_addr != 0) begin
                    e.v = 1'b1;
                    e.a = l_addr;
                    e.d = l_data;
                    mq.push_back(e);
                end
            end
        end
    end

    task automatic drive(input logic r, input logic pv, input logic [1:0] ps,
                         input logic [4:0] rt, input logic [4:0] rd, input logic [31:0] pd,
                         input logic lv, input logic [4:0] la, input logic [31:0] ld);
        rst = r; p_valid = pv; p_sel = ps; p_rt = rt; p_rd = rd; p_data = pd;
        l_valid = lv; l_addr = la; l_data = ld;
    endtask

    task automatic idle();
        drive(0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        tick(); tick();
        check("rst_rf_we", 32'(rf_we), 0);
        check("rst_rf_waddr", 32'(rf_waddr), 0);
        check("rst_rf_wdata", rf_wdata, 0);
        check("rst_pq_count", 32'(pq_count), 0);
        check("rst_l_ready", 32'(l_ready), 0);

        idle(); #1;
        check("release_l_ready", 32'(l_ready), 1);
        tick();

        // pipeline writes via rd and link select
        drive(0, 1, 2'b01, 5'd3, 5'd5, 32'hA5A5A5A5, 0, 0, 0); #1;
        check("p_rd_stall", 32'(p_stall), 0);
        tick();
        check("p_rd_we", 32'(rf_we), 1);
        check("p_rd_waddr", 32'(rf_waddr), 5);
        check("p_rd_wdata", rf_wdata, 32'hA5A5A5A5);
        drive(0, 1, 2'b10, 5'd3, 5'd4, 32'h1111, 0, 0, 0);
        tick();
        check("p_link10_waddr", 32'(rf_waddr), 31);
        drive(0, 1, 2'b11, 5'd3, 5'd4, 32'h2222, 0, 0, 0);
        tick();
        check("p_link11_waddr", 32'(rf_waddr), 31);
        check("p_link11_wdata", rf_wdata, 32'h2222);
        idle();
        tick();
        check("idle_we", 32'(rf_we), 0);

        // single long-latency result
        drive(0, 0, 2'b00, 0, 0, 0, 1, 5'd8, 32'h12);
        tick();
        check("l_enq_count", 32'(pq_count), 1);
        check("l_enq_we", 32'(rf_we), 0);
        idle();
        tick();
        check("l_drain_we", 32'(rf_we), 1);
        check("l_drain_waddr", 32'(rf_waddr), 8);
        check("l_drain_wdata", rf_wdata, 32'h12);
        check("l_drain_count", 32'(pq_count), 0);

        // fill queue while pipeline keeps requesting
        drive(0, 0, 2'b00, 0, 0, 0, 1, 5'd3, 32'h33);
        tick();
        drive(0, 1, 2'b00, 5'd9, 0, 32'h9, 1, 5'd4, 32'h44);
        tick();
        check("fill_count", 32'(pq_count), 2);
        check("fill_waddr9", 32'(rf_waddr), 9);
        drive(0, 1, 2'b00, 5'd9, 0, 32'h9, 0, 0, 0); #1;
        check("full_stall", 32'(p_stall), 1);
        check("full_l_ready", 32'(l_ready), 0);
        tick();
        check("forced_waddr", 32'(rf_waddr), 3);
        check("forced_wdata", rf_wdata, 32'h33);
        check("forced_count", 32'(pq_count), 1);
        drive(0, 1, 2'b00, 5'd9, 0, 32'h99, 0, 0, 0); #1;
        check("regrant_stall", 32'(p_stall), 0);
        tick();
        check("regrant_waddr", 32'(rf_waddr), 9);
        check("regrant_wdata", rf_wdata, 32'h99);
        idle();
        tick();
        check("tail_waddr", 32'(rf_waddr), 4);
        check("tail_wdata", rf_wdata, 32'h44);
        check("tail_count", 32'(pq_count), 0);

        // WAW squash
        drive(0, 0, 2'b00, 0, 0, 0, 1, 5'd7, 32'h1);
        tick();
        drive(0, 1, 2'b01, 0, 5'd7, 32'h2, 0, 0, 0);
        tick();
        check("waw_we", 32'(rf_we), 1);
        check("waw_wdata", rf_wdata, 32'h2);
        check("waw_count", 32'(pq_count), 1);
        idle();
        tick();
        check("squash_we", 32'(rf_we), 0);
        check("squash_count", 32'(pq_count), 0);
        tick();
        check("squash_after_we", 32'(rf_we), 0);

        // same-address arrival with a grant is not squashed
        drive(0, 1, 2'b00, 5'd6, 0, 32'h60, 1, 5'd6, 32'h61);
        tick();
        check("same_cyc_waddr", 32'(rf_waddr), 6);
        idle();
        tick();
        check("same_cyc_drain_we", 32'(rf_we), 1);
        check("same_cyc_drain_wdata", rf_wdata, 32'h61);

        // r0 traffic
        drive(0, 1, 2'b00, 5'd0, 5'd9, 32'hDEAD, 1, 5'd0, 32'hBEEF); #1;
        check("r0_stall", 32'(p_stall), 0);
        tick();
        check("r0_we", 32'(rf_we), 0);
        check("r0_count", 32'(pq_count), 0);

        // reset with two queued entries
        drive(0, 1, 2'b00, 5'd0, 0, 0, 1, 5'd10, 32'hA0);
        tick();
        drive(0, 1, 2'b00, 5'd0, 0, 0, 1, 5'd11, 32'hB0);
        tick();
        check("pre_rst_count", 32'(pq_count), 2);
        drive(1, 1, 2'b00, 5'd12, 0, 32'hC0, 1, 5'd13, 32'hD0); #1;
        check("in_rst_stall", 32'(p_stall), 0);
        check("in_rst_count", 32'(pq_count), 0);
        check("in_rst_l_ready", 32'(l_ready), 0);
        tick();
        idle(); #1;
        check("post_rst_we", 32'(rf_we), 0);
        check("post_rst_waddr", 32'(rf_waddr), 0);
        check("post_rst_wdata", rf_wdata, 0);
        check("post_rst_l_ready", 32'(l_ready), 1);
        tick(); tick(); tick();
        check("post_rst_quiet_we", 32'(rf_we), 0);
        check("post_rst_quiet_count", 32'(pq_count), 0);

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
